rf_scoreboard_mp: RTL

- Parametrised multi-read-port integer register file with a per-register busy scoreboard, for the pipelined core's decode/writeback stages.
- Decode allocates a destination register (sets busy) and writeback writes data (clears busy).
- Read ports return data plus a busy flag so the hazard unit can stall on RAW or WAW dependencies.
- Register 0 is optionally hardwired to zero.

---
 rtl/rf_scoreboard_mp_if.sv | 32 +++
 rtl/rf_scoreboard_mp.sv | 86 ++++++++
 2 files changed

// File: rtl/rf_scoreboard_mp_if.sv
// Bundle of read, writeback, allocation and flush signals for rf_scoreboard_mp.
// The master modport is the pipeline side (decode, writeback, hazard unit). The slave modport is the register file.
interface rf_scoreboard_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
);
  // Handshake: decode holds alloc_en/alloc_addr stable and watches alloc_ok, which is combinational.
  // An allocation is accepted on a rising edge where alloc_en and alloc_ok are both high.
  // If it is refused, decode retries on a later cycle. The rd_*, busy_vec, we and flush signals carry no handshake.
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_busy;
  logic                         we;
  logic [ADDR_WIDTH-1:0]        wa;
  logic [DATA_WIDTH-1:0]        wd;
  logic                         alloc_en;
  logic [ADDR_WIDTH-1:0]        alloc_addr;
  logic                         alloc_ok;
  logic                         flush;
  logic [(1<<ADDR_WIDTH)-1:0]   busy_vec;

  modport master (
    output rd_addr, we, wa, wd, alloc_en, alloc_addr, flush,
    input  rd_data, rd_busy, alloc_ok, busy_vec
  );

  modport slave (
    input  rd_addr, we, wa, wd, alloc_en, alloc_addr, flush,
    output rd_data, rd_busy, alloc_ok, busy_vec
  );
endinterface

// File: rtl/rf_scoreboard_mp.sv
// Multi-read-port register file with a per-register busy scoreboard for decode and writeback.
// Optional macro RF_SCB_BYPASS_EN enables write-through bypass on the read ports.
module rf_scoreboard_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,   // legal range 1..4
  parameter int ZERO_REG   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rf_scoreboard_mp_if.slave    bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]        r_regs [DEPTH];
  logic [DEPTH-1:0]             r_busy;

  logic                         w_wr_ok;
  logic                         w_alloc_ok;
  logic                         w_alloc_set;
  logic [DEPTH-1:0]             w_busy_nxt;
  logic [NUM_RD*DATA_WIDTH-1:0] w_rd_data;
  logic [NUM_RD-1:0]            w_rd_busy;
  logic [ADDR_WIDTH-1:0]        w_raddr;

  // A hardwired zero register swallows writes and never records a producer.
  assign w_wr_ok     = bus.we && !((ZERO_REG != 0) && (bus.wa == '0));
  assign w_alloc_ok  = bus.alloc_en &&
                       (!r_busy[bus.alloc_addr] || (bus.we && (bus.wa == bus.alloc_addr)));
  assign w_alloc_set = w_alloc_ok && !((ZERO_REG != 0) && (bus.alloc_addr == '0));

  // Set beats clear: a same-cycle allocation names a new producer. Flush beats both.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok) w_busy_nxt[bus.wa] = 1'b0;
    if (bus.flush) begin
      w_busy_nxt = '0;
    end else if (w_alloc_set) begin
      w_busy_nxt[bus.alloc_addr] = 1'b1;
    end
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[bus.wa] <= bus.wd;
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    w_raddr   = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_raddr = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      w_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_raddr];
      w_rd_busy[k] = r_busy[w_raddr];
`ifdef RF_SCB_BYPASS_EN
      // A write in flight is visible now. The register stays busy only if it is being reallocated.
      if (w_wr_ok && (w_raddr == bus.wa)) begin
        w_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = bus.wd;
        w_rd_busy[k] = w_alloc_ok && (bus.alloc_addr == bus.wa);
      end
`endif
      if ((ZERO_REG != 0) && (w_raddr == '0)) begin
        w_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        w_rd_busy[k] = 1'b0;
      end
    end
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_busy  = w_rd_busy;
  assign bus.alloc_ok = w_alloc_ok;
  assign bus.busy_vec = r_busy;
endmodule
